zircon_avalon_buzzer_seq: RTL

ZIRCON_AVALON_BUZZER_SEQ -- requirements
Module: zircon_avalon_buzzer_seq

---
 rtl/zircon_avalon_buzzer_seq.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/zircon_avalon_buzzer_seq.sv
// zircon_avalon_buzzer_seq
//   Avalon-MM slave that queues buzzer notes and plays them back in order.
//   Each note holds a PWM divide value and a duration in ticks. A note plays
//   for duration*TICK_CYCLES clocks and is followed by a one-tick silent gap.
//
// Ports
//   csi_clk, rsi_reset         clock, asynchronous active-high reset
//   avs_address/write/read     register select and strobes
//   avs_writedata/readdata     32-bit data, read latency 1 (readdata holds)
//   pwm_clock_divide           zero-extended divide of the current note
//   pwm_duty_cycle             divide>>1 (50% duty)
//   pwm_enable                 high while a non-rest note is playing
//   ins_irq                    done & irq_en, registered (BUZZER_SEQ_IRQ_EN only)
//
// Registers
//   0 NOTE   (W)  [19:0] divide, [31:20] duration in ticks
//   1 CTRL   (RW) bit0 run, bit1 flush (self-clearing), bit2 irq_en
//   2 STATUS (R)  bit0 busy, bit1 full, bit2 empty, bit3 overflow, bit4 done,
//                 [11:8] count; write 1 to bit3/bit4 clears it
//   3 reserved, reads 0
//
// Optional feature macro: BUZZER_SEQ_IRQ_EN (adds ins_irq and CTRL.irq_en).

module zircon_avalon_buzzer_seq #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TICK_CYCLES = 50000
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [31:0] pwm_clock_divide,
    output logic [31:0] pwm_duty_cycle,
    output logic        pwm_enable
`ifdef BUZZER_SEQ_IRQ_EN
    ,
    output logic        ins_irq
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t         state_q, state_d;
    logic           run_q, run_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [11:0]    ticks_q, ticks_d;
    logic [19:0]    div_q, div_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    mem_q [FIFO_DEPTH];

    logic           wr_note, wr_ctrl, wr_stat, flush, abort;
    logic           full, empty, push, pop, done_set, ovf_set, tick_end;
    logic           irq_en_cur;
    logic [31:0]    head, cnt_ext, status;

`ifdef BUZZER_SEQ_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;
    assign irq_en_cur = irq_en_q;
    assign ins_irq    = irq_q;
`else
    assign irq_en_cur = 1'b0;
`endif

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign cnt_ext = 32'(count_q);
    // At FIFO_DEPTH=16 a full queue wraps the 4-bit count field to 0; full=1 disambiguates.
    assign status  = {20'b0, cnt_ext[3:0], 3'b0, done_q, ovf_q, empty, full, state_q != S_IDLE};
    assign tick_end = (presc_q == PW'(TICK_CYCLES - 1));

    always_comb begin
        wr_note  = avs_write && (avs_address == 2'd0);
        wr_ctrl  = avs_write && (avs_address == 2'd1);
        wr_stat  = avs_write && (avs_address == 2'd2);
        flush    = wr_ctrl && avs_writedata[1];
        run_d    = wr_ctrl ? avs_writedata[0] : run_q;
        // Clearing run (or flushing) takes effect on the very next edge.
        abort    = flush || !run_d;
        pop      = (state_q == S_LOAD) && !abort;
        // Flush beats a same-cycle push; a pop frees the slot even when full.
        push     = wr_note && !flush && (!full || pop);
        ovf_set  = wr_note && !flush && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        state_d  = state_q;
        presc_d  = presc_q;
        ticks_d  = ticks_q;
        div_d    = div_q;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: if (!abort && count_d != '0) state_d = S_LOAD;
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    div_d = head[19:0];
                    if (head[31:20] == 12'd0) begin
                        // Zero-duration note is skipped without a gap.
                        if (count_d != '0) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d  = S_IDLE;
                            done_set = 1'b1;
                        end
                    end else begin
                        state_d = S_PLAY;
                        presc_d = '0;
                        ticks_d = head[31:20];
                    end
                end
            end
            S_PLAY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tick_end) begin
                    presc_d = '0;
                    if (ticks_q == 12'd1) state_d = S_GAP;
                    else ticks_d = ticks_q - 12'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tick_end) begin
                    presc_d = '0;
                    if (count_d != '0) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d  = S_IDLE;
                        done_set = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A set in the same cycle as a clear wins so the event is not lost.
        ovf_d  = ovf_set  || (ovf_q  && !(wr_stat && avs_writedata[3]));
        done_d = done_set || (done_q && !(wr_stat && avs_writedata[4]));

        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                2'd1:    rdata_d = {29'b0, irq_en_cur, 1'b0, run_q};
                2'd2:    rdata_d = status;
                default: rdata_d = 32'b0;
            endcase
        end
    end

`ifdef BUZZER_SEQ_IRQ_EN
    always_comb begin
        irq_en_d = wr_ctrl ? avs_writedata[2] : irq_en_q;
        irq_d    = done_q & irq_en_q;
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`endif

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            ticks_q  <= '0;
            div_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            ticks_q  <= ticks_d;
            div_q    <= div_d;
            rdata_q  <= rdata_d;
        end
    end

    // Queue storage needs no reset; only entries below count are ever read.
    always_ff @(posedge csi_clk) begin
        if (push) mem_q[wr_ptr_q] <= avs_writedata;
    end

    assign avs_readdata     = rdata_q;
    assign pwm_clock_divide = {12'b0, div_q};
    assign pwm_duty_cycle   = {13'b0, div_q[19:1]};
    // Reset forces state_q to IDLE asynchronously, silencing the buzzer at once.
    assign pwm_enable       = (state_q == S_PLAY) && (div_q != 20'd0);

endmodule
